// File: rtl/seg7_pkg.sv
// Shared constants, hex segment table and load FSM encoding for seg7_scan_8.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-high {g,f,e,d,c,b,a}, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {IDLE, PEND} load_st_e;

  // Index of the most significant nonzero nibble; 0 for an all-zero word.
  function automatic logic [2:0] top_digit(logic [31:0] v);
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[4*i +: 4] != 4'h0) r = 3'(i);
    return r;
  endfunction

endpackage

// File: rtl/seg7_scan_8_if.sv
// Load/ack capture handshake between the counter source and the scanner.
interface seg7_scan_8_if;
  logic [31:0] value;
  logic [7:0]  dp_mask;
  logic        load;
  logic        ack;

  modport master (output value, dp_mask, load, input ack);
  modport slave  (input value, dp_mask, load, output ack);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-high seven-segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg7_scan_8.sv
// Eight-digit multiplexed hex display scanner with frame-aligned load capture.
// Optional leading-zero blanking: define SEG7_BLANK_EN.
module seg7_scan_8
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV   = 100000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  seg7_scan_8_if.slave  bus,
  output logic          frame_tick,
  output logic [7:0]    an,
  output logic [6:0]    seg,
  output logic          dp
);
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  // Inactive output levels; XOR with these also applies the polarity.
  localparam logic [7:0] AN_OFF  = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = ACTIVE_LOW;

  logic [DW-1:0] div, div_n;
  logic [2:0]    idx, idx_n;
  logic          tc;
  load_st_e      st, st_n;
  logic          capture, ack_q;
  logic [31:0]   shadow, shadow_n;
  logic [7:0]    dpsh, dpsh_n;
  logic [NUM_DIGITS-1:0][6:0] dig_seg;
  logic [7:0]    an_act;

  assign tc         = (div == DW'(SCAN_DIV - 1));
  assign frame_tick = tc && (idx == 3'd7);
  assign div_n      = tc ? '0 : div + DW'(1);
  assign idx_n      = tc ? idx + 3'd1 : idx;
  assign shadow_n   = capture ? bus.value   : shadow;
  assign dpsh_n     = capture ? bus.dp_mask : dpsh;
  assign bus.ack    = ack_q;

  always_comb begin
    st_n    = st;
    capture = 1'b0;
    case (st)
      IDLE: if (bus.load) begin
        if (frame_tick) capture = 1'b1;
        else            st_n    = PEND;
      end
      PEND: if (frame_tick) begin
        capture = 1'b1;
        st_n    = IDLE;
      end
      default: st_n = IDLE;
    endcase
  end

  // Decode from the post-edge shadow so a fresh capture shows on digit 0 at once.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_hex_decode u_dec (.nib(shadow_n[4*g +: 4]), .seg(dig_seg[g]));
  end

  always_comb begin
    an_act = 8'h01 << idx_n;
`ifdef SEG7_BLANK_EN
    if (idx_n > top_digit(shadow_n)) an_act = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div    <= '0;
      idx    <= '0;
      st     <= IDLE;
      shadow <= '0;
      dpsh   <= '0;
      ack_q  <= 1'b0;
      an     <= AN_OFF;
      seg    <= SEG_OFF;
      dp     <= DP_OFF;
    end else begin
      div    <= div_n;
      idx    <= idx_n;
      st     <= st_n;
      shadow <= shadow_n;
      dpsh   <= dpsh_n;
      ack_q  <= capture;
      an     <= an_act ^ AN_OFF;
      seg    <= dig_seg[idx_n] ^ SEG_OFF;
      dp     <= dpsh_n[idx_n] ^ DP_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_8.sv
// Directed bench for seg7_scan_8 with SCAN_DIV=4, ACTIVE_LOW=1.
module tb_seg7_scan_8;
  localparam int SD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_8_if bus ();
  logic       frame_tick;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  seg7_scan_8 #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .frame_tick(frame_tick), .an(an), .seg(seg), .dp(dp)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;  // edges since last reset release

  function automatic logic [7:0] exp_an(int idx, int top);
    logic [7:0] o;
`ifdef SEG7_BLANK_EN
    if (idx > top) return 8'hFF;
`endif
    o = 8'h01 << idx;
    return ~o;
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Advance to edge count `target`, expecting no ack and a frame_tick every 32 cycles.
  task automatic idle_to(int target);
    while (k < target) begin
      tick();
      check("ack_quiet", 32'(bus.ack), 0);
      check("ftick", 32'(frame_tick), 32'(k % 32 == 31));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.dp_mask = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_an", 32'(an), 32'hFF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 1);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_ftick", 32'(frame_tick), 0);

    rst = 1'b0; k = 0;
    tick();
    check("first_an", 32'(an), 32'hFE);
    check("first_seg", 32'(seg), 32'h40);
    check("first_dp", 32'(dp), 1);

    // scan cadence
    while (k < 40) begin
      tick();
      check("cad_an", 32'(an), 32'(exp_an((k / 4) % 8, 0)));
      check("cad_ftick", 32'(frame_tick), 32'(k % 32 == 31));
      if (k % 32 == 31) check("cad_ft_an", 32'(an), 32'h7F);
    end

    // mid-frame load at idx=3; value changes before the boundary
    idle_to(44);
    bus.load = 1'b1; bus.value = 32'h12345678; bus.dp_mask = 8'h80;
    tick();
    bus.load = 1'b0; bus.value = 32'hDEADBEEF; bus.dp_mask = 8'h81;
    check("mid_ack_early", 32'(bus.ack), 0);
    idle_to(63);
    tick();
    check("mid_ack", 32'(bus.ack), 1);
    check("mid_an0", 32'(an), 32'hFE);
    check("mid_seg0", 32'(seg), 32'h0E);
    check("mid_dp0", 32'(dp), 0);
    idle_to(68);
    check("mid_an1", 32'(an), 32'hFD);
    check("mid_seg1", 32'(seg), 32'h06);
    check("mid_dp1", 32'(dp), 1);
    idle_to(92);
    check("mid_an7", 32'(an), 32'h7F);
    check("mid_seg7", 32'(seg), 32'h21);
    check("mid_dp7", 32'(dp), 0);

    // load coincident with frame_tick
    idle_to(95);
    check("co_ftick", 32'(frame_tick), 1);
    bus.load = 1'b1; bus.value = 32'h12345678; bus.dp_mask = 8'h00;
    tick();
    bus.load = 1'b0;
    check("co_ack", 32'(bus.ack), 1);
    check("co_an", 32'(an), 32'hFE);
    check("co_seg", 32'(seg), 32'h00);
    check("co_dp", 32'(dp), 1);
    tick();
    check("co_ack_end", 32'(bus.ack), 0);

    // two loads while pending give one ack
    idle_to(100);
    bus.load = 1'b1; bus.value = 32'h11111111;
    tick();
    bus.load = 1'b0;
    idle_to(105);
    bus.load = 1'b1; bus.value = 32'h22222222;
    tick();
    bus.load = 1'b0; bus.value = 32'hA0000000;
    idle_to(127);
    tick();
    check("pend_ack", 32'(bus.ack), 1);
    check("pend_an0", 32'(an), 32'hFE);
    check("pend_seg0", 32'(seg), 32'h40);
    idle_to(156);
    check("pend_an7", 32'(an), 32'h7F);
    check("pend_seg7", 32'(seg), 32'h08);
    idle_to(160);

    // async reset between edges at idx=5 with a load pending
    idle_to(161);
    bus.load = 1'b1;
    tick();
    bus.load = 1'b0; bus.value = 32'hFFFFFFFF;
    idle_to(181);
    check("ar_an_pre", 32'(an), 32'hDF);
    #2;
    rst = 1'b1;
    #1;
    check("ar_an", 32'(an), 32'hFF);
    check("ar_seg", 32'(seg), 32'h7F);
    check("ar_dp", 32'(dp), 1);
    check("ar_ack", 32'(bus.ack), 0);
    check("ar_ftick", 32'(frame_tick), 0);
    @(posedge clk);
    #1;
    rst = 1'b0; k = 0;
    while (k < 40) begin
      tick();
      check("ar_noack", 32'(bus.ack), 0);
      check("ar_seg0", 32'(seg), 32'h40);
      check("ar_scan", 32'(an), 32'(exp_an((k / 4) % 8, 0)));
    end

`ifdef SEG7_BLANK_EN
    begin
      int n;
      bus.load = 1'b1; bus.value = 32'h00000A05;
      tick();
      bus.load = 1'b0;
      n = 0;
      while (!bus.ack && n < 40) begin tick(); n++; end
      check("bl_ack", 32'(bus.ack), 1);
      for (int i = 0; i < 32; i++) begin
        check("bl_an_a05", 32'(an), 32'(exp_an((k / 4) % 8, 2)));
        tick();
      end
      bus.load = 1'b1; bus.value = 32'h0;
      tick();
      bus.load = 1'b0;
      n = 0;
      while (!bus.ack && n < 40) begin tick(); n++; end
      check("bl_ack0", 32'(bus.ack), 1);
      for (int i = 0; i < 32; i++) begin
        check("bl_an_zero", 32'(an), 32'(exp_an((k / 4) % 8, 0)));
        tick();
      end
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
